// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control path.
//   state_t   : controller states
//   OP_*      : instruction class codes from IR op field
//   ALU_*     : alu_control encodings
//   CMD_*     : DP cmd field values recognised by the ALU decoder
//   ADR_*, SRCB_*, RES_*, IMM_* : datapath mux select encodings
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'd0;
  localparam logic [1:0] OP_MEM = 2'd1;
  localparam logic [1:0] OP_BR  = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALU    = 1'b1;
  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] IMM_DP     = 2'b00;
  localparam logic [1:0] IMM_MEM    = 2'b01;
  localparam logic [1:0] IMM_BR     = 2'b10;

  // Extender mode implied by instruction class (undefined class -> DP).
  function automatic logic [1:0] imm_for_op(input logic [1:0] op);
    case (op)
      OP_MEM:  imm_for_op = IMM_MEM;
      OP_BR:   imm_for_op = IMM_BR;
      default: imm_for_op = IMM_DP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle.
//   master : controller side (IR fields, cond_ex, mem_ready in; selects/strobes out)
//   slave  : datapath/memory side
interface multicycle_ctrl_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       cond_ex;
  logic       mem_ready;
  logic       mem_req;
  logic       pc_w;
  logic       ir_w;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       reg_w;
  logic       mem_w;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [1:0] alu_control;
  logic [1:0] flag_w;

  modport master (
    input  op, funct, rd, cond_ex, mem_ready,
    output mem_req, pc_w, ir_w, adr_src, alu_src_a, alu_src_b, result_src,
           reg_w, mem_w, imm_src, reg_src, alu_control, flag_w
  );

  modport slave (
    output op, funct, rd, cond_ex, mem_ready,
    input  mem_req, pc_w, ir_w, adr_src, alu_src_a, alu_src_b, result_src,
           reg_w, mem_w, imm_src, reg_src, alu_control, flag_w
  );
endinterface

// File: rtl/alu_dec.sv
// DP funct decoder. With alu_op low both outputs are 0 (ADD, no flag writes).
//   alu_op      : FSM is in an execute state
//   funct       : [4:1] cmd, [0] S bit
//   alu_control : ALU operation
//   flag_w      : [1] NZ write, [0] CV write (arithmetic ops only)
module alu_dec
  import ctrl_pkg::*;
(
  input  logic       alu_op,
  input  logic [5:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);
  logic [3:0] cmd;
  logic       arith;

  assign cmd   = funct[4:1];
  assign arith = (cmd == CMD_ADD) || (cmd == CMD_SUB);

  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (cmd)
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
        default: alu_control = ALU_ADD;
      endcase
      flag_w = {funct[0], funct[0] & arith};
    end
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencing controller for the multicycle core.
//   clk   : system clock
//   reset : synchronous active-high; forces FETCH and masks every output
//   bus   : controller side of multicycle_ctrl_if
// Outputs are combinational from state, IR fields and mem_ready.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);
  state_t     state;
  logic       alu_op;
  logic [1:0] dec_alu;
  logic [1:0] dec_flag;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else begin
      case (state)
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (!bus.cond_ex) state <= S_FETCH;
          else begin
            case (bus.op)
              OP_DP:   state <= bus.funct[5] ? S_EXECI : S_EXECR;
              OP_MEM:  state <= S_MEMADR;
              OP_BR:   state <= S_BRANCH;
              default: state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR: state <= bus.funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
        S_EXECR,
        S_EXECI:  state <= S_ALUWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  assign alu_op = !reset && (state == S_EXECR || state == S_EXECI);

  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct       (bus.funct),
    .alu_control (dec_alu),
    .flag_w      (dec_flag)
  );

  assign bus.alu_control = dec_alu;
  assign bus.flag_w      = dec_flag;

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.pc_w       = 1'b0;
    bus.ir_w       = 1'b0;
    bus.adr_src    = ADR_PC;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_WD;
    bus.result_src = RES_ALUOUT;
    bus.reg_w      = 1'b0;
    bus.mem_w      = 1'b0;
    bus.imm_src    = IMM_DP;
    bus.reg_src    = 2'b00;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          bus.mem_req    = 1'b1;
          bus.alu_src_a  = 1'b1;
          bus.alu_src_b  = SRCB_4;
          bus.result_src = RES_ALURES;
          bus.ir_w       = bus.mem_ready;
          bus.pc_w       = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_src_b  = SRCB_4;
          bus.result_src = RES_ALURES;
          bus.imm_src    = imm_for_op(bus.op);
          bus.reg_src    = {bus.op == OP_MEM, bus.op == OP_BR};
        end
        S_MEMADR: begin
          bus.alu_src_b = SRCB_IMM;
          bus.imm_src   = IMM_MEM;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.adr_src = ADR_ALU;
        end
        S_MEMWR: begin
          bus.mem_req = 1'b1;
          bus.mem_w   = 1'b1;
          bus.adr_src = ADR_ALU;
        end
        S_MEMWB: begin
          bus.result_src = RES_DATA;
          bus.reg_w      = 1'b1;
          bus.pc_w       = (bus.rd == 4'd15);
        end
        S_EXECR: bus.alu_src_b = SRCB_WD;
        S_EXECI: begin
          bus.alu_src_b = SRCB_IMM;
          bus.imm_src   = IMM_DP;
        end
        S_ALUWB: begin
          bus.result_src = RES_ALUOUT;
          bus.reg_w      = 1'b1;
          bus.pc_w       = (bus.rd == 4'd15);
        end
        S_BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_src_b  = SRCB_IMM;
          bus.imm_src    = IMM_BR;
          bus.result_src = RES_ALURES;
          bus.pc_w       = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Per-instruction observable totals.
  typedef struct {
    int cycles;
    int reg_w;
    int pc_w;
    int mem_w;
    int mem_req;
    int alu;
    int flag;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond;
    int         wf;
    int         wm;
    exp_t       e;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Reference: cycle counts and strobe totals from the instruction rules.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    logic [3:0] cmd;
    cmd = v.funct[4:1];
    e = '{cycles: 2 + v.wf, reg_w: 0, pc_w: 1, mem_w: 0, mem_req: 1 + v.wf, alu: 0, flag: 0};
    if (v.cond && v.op != 2'd3) begin
      if (v.op == 2'd0) begin
        e.cycles += 2;
        e.reg_w = 1;
        e.pc_w += (v.rd == 15) ? 1 : 0;
        e.alu = (cmd == 4'b0010) ? 1 : (cmd == 4'b0000) ? 2 : (cmd == 4'b1100) ? 3 : 0;
        e.flag = (v.funct[0] ? 2 : 0) + ((v.funct[0] && (cmd == 4'b0100 || cmd == 4'b0010)) ? 1 : 0);
      end else if (v.op == 2'd1) begin
        e.mem_req += 1 + v.wm;
        if (v.funct[0]) begin
          e.cycles += 3 + v.wm;
          e.reg_w = 1;
          e.pc_w += (v.rd == 15) ? 1 : 0;
        end else begin
          e.cycles += 2 + v.wm;
          e.mem_w = 1 + v.wm;
        end
      end else begin
        e.cycles += 1;
        e.pc_w += 1;
      end
    end
    return e;
  endfunction

  // Runs one instruction from the first FETCH cycle up to the next FETCH,
  // acting as a memory that inserts the requested wait cycles.
  task automatic run_instr(input vec_t v, input string nm);
    exp_t got;
    int fw, mw, budget;
    bit ir_seen;
    got = '{default: 0};
    fw = v.wf; mw = v.wm; ir_seen = 0; budget = 0;
    bus.op = v.op; bus.funct = v.funct; bus.rd = v.rd; bus.cond_ex = v.cond;
    forever begin
      if (ir_seen && bus.mem_req && !bus.adr_src) break;
      if (budget > 60) begin
        chk({nm, " timeout"}, budget, 0);
        break;
      end
      if (bus.mem_req && !bus.adr_src) begin
        bus.mem_ready = (fw == 0); if (fw > 0) fw--;
      end else if (bus.mem_req) begin
        bus.mem_ready = (mw == 0); if (mw > 0) mw--;
      end else bus.mem_ready = 1'($urandom_range(1));
      #1;
      budget++;
      got.cycles++;
      got.reg_w   += int'(bus.reg_w);
      got.pc_w    += int'(bus.pc_w);
      got.mem_w   += int'(bus.mem_w & bus.mem_req);
      got.mem_req += int'(bus.mem_req);
      got.alu  |= int'(bus.alu_control);
      got.flag |= int'(bus.flag_w);
      if (bus.ir_w) ir_seen = 1;
      nxt();
    end
    chk({nm, " cycles"},  got.cycles,  v.e.cycles);
    chk({nm, " reg_w"},   got.reg_w,   v.e.reg_w);
    chk({nm, " pc_w"},    got.pc_w,    v.e.pc_w);
    chk({nm, " mem_w"},   got.mem_w,   v.e.mem_w);
    chk({nm, " mem_req"}, got.mem_req, v.e.mem_req);
    chk({nm, " alu"},     got.alu,     v.e.alu);
    chk({nm, " flag_w"},  got.flag,    v.e.flag);
  endtask

  task automatic set_ir(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input logic c);
    bus.op = op; bus.funct = f; bus.rd = rd; bus.cond_ex = c;
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    set_ir(2'd0, 6'd0, 4'd0, 1'b1);

    tbl[0] = '{2'd0, 6'b001000, 4'd3,  1'b1, 0, 0, '{4, 1, 1, 0, 1, 0, 0}};
    tbl[1] = '{2'd0, 6'b100101, 4'd2,  1'b1, 0, 0, '{4, 1, 1, 0, 1, 1, 3}};
    tbl[2] = '{2'd0, 6'b000000, 4'd15, 1'b1, 0, 0, '{4, 1, 2, 0, 1, 2, 0}};
    tbl[3] = '{2'd0, 6'b011001, 4'd1,  1'b1, 0, 0, '{4, 1, 1, 0, 1, 3, 2}};
    tbl[4] = '{2'd1, 6'b000001, 4'd15, 1'b1, 1, 2, '{8, 1, 2, 0, 5, 0, 0}};
    tbl[5] = '{2'd1, 6'b000000, 4'd4,  1'b1, 0, 1, '{5, 0, 1, 2, 3, 0, 0}};
    tbl[6] = '{2'd2, 6'b000000, 4'd0,  1'b0, 0, 0, '{2, 0, 1, 0, 1, 0, 0}};
    tbl[7] = '{2'd2, 6'b000000, 4'd0,  1'b1, 2, 0, '{5, 0, 2, 0, 3, 0, 0}};
    tbl[8] = '{2'd3, 6'b000000, 4'd0,  1'b1, 0, 0, '{2, 0, 1, 0, 1, 0, 0}};
    tbl[9] = '{2'd0, 6'b000011, 4'd5,  1'b1, 0, 0, '{4, 1, 1, 0, 1, 0, 2}};

    // Reset: everything masked even with mem_ready high.
    nxt(); nxt();
    chk("rst mem_req", int'(bus.mem_req), 0);
    chk("rst strobes", int'({bus.pc_w, bus.ir_w, bus.reg_w, bus.mem_w, bus.flag_w}), 0);
    chk("rst selects", int'({bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src,
                             bus.imm_src, bus.reg_src, bus.alu_control}), 0);
    reset = 1'b0;
    #1;
    chk("post-rst mem_req", int'(bus.mem_req), 1);

    // ADD r3: FETCH, DECODE, EXECR, ALUWB.
    set_ir(2'd0, 6'b001000, 4'd3, 1'b1); bus.mem_ready = 1'b1; #1;
    chk("add f ir_w", int'(bus.ir_w), 1);
    chk("add f pc_w", int'(bus.pc_w), 1);
    chk("add f srcb", int'(bus.alu_src_b), 2);
    nxt();
    chk("add d srca", int'(bus.alu_src_a), 1);
    chk("add d res", int'(bus.result_src), 2);
    chk("add d reg_w", int'(bus.reg_w), 0);
    nxt();
    chk("add e srcab", int'({bus.alu_src_a, bus.alu_src_b}), 0);
    chk("add e alu/flag", int'({bus.alu_control, bus.flag_w}), 0);
    chk("add e reg_w", int'(bus.reg_w), 0);
    nxt();
    chk("add wb reg_w", int'(bus.reg_w), 1);
    chk("add wb pc_w", int'(bus.pc_w), 0);
    chk("add wb res", int'(bus.result_src), 0);
    nxt();
    chk("add back fetch", int'({bus.mem_req, bus.adr_src}), 2);

    // SUBS imm r2: EXECI controls.
    set_ir(2'd0, 6'b100101, 4'd2, 1'b1); #1;
    nxt(); nxt();
    chk("subs alu", int'(bus.alu_control), 1);
    chk("subs flag_w", int'(bus.flag_w), 3);
    chk("subs srcb", int'(bus.alu_src_b), 1);
    chk("subs imm", int'(bus.imm_src), 0);
    nxt(); nxt();

    // LDR r15 with two wait cycles in MEMRD.
    set_ir(2'd1, 6'b000001, 4'd15, 1'b1); bus.mem_ready = 1'b1; #1;
    nxt();
    chk("ldr d imm", int'(bus.imm_src), 1);
    chk("ldr d regsrc", int'(bus.reg_src), 2);
    nxt();
    chk("ldr adr srcb", int'(bus.alu_src_b), 1);
    chk("ldr adr mem_req", int'(bus.mem_req), 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      bus.mem_ready = (i == 2); #1;
      chk($sformatf("ldr rd%0d req/adr", i), int'({bus.mem_req, bus.adr_src}), 3);
      chk($sformatf("ldr rd%0d reg_w", i), int'(bus.reg_w), 0);
    end
    nxt();
    chk("ldr wb reg_w", int'(bus.reg_w), 1);
    chk("ldr wb pc_w", int'(bus.pc_w), 1);
    chk("ldr wb res", int'(bus.result_src), 1);
    nxt();

    // STR: write strobe with request, no register write.
    set_ir(2'd1, 6'b000000, 4'd4, 1'b1); bus.mem_ready = 1'b1; #1;
    nxt(); nxt(); nxt();
    chk("str mem_w/req", int'({bus.mem_w, bus.mem_req, bus.adr_src}), 7);
    chk("str reg_w", int'(bus.reg_w), 0);
    nxt();
    chk("str back fetch", int'({bus.mem_req, bus.adr_src}), 2);

    // Branch not taken, then taken.
    set_ir(2'd2, 6'b000000, 4'd0, 1'b0); #1;
    nxt();
    chk("bnt d imm", int'(bus.imm_src), 2);
    chk("bnt d regsrc", int'(bus.reg_src), 1);
    nxt();
    chk("bnt fetch", int'({bus.mem_req, bus.adr_src}), 2);
    bus.cond_ex = 1'b1; #1;
    nxt(); nxt();
    chk("b pc_w", int'(bus.pc_w), 1);
    chk("b imm", int'(bus.imm_src), 2);
    chk("b srcab", int'({bus.alu_src_a, bus.alu_src_b}), 5);
    nxt();

    // Reset in FETCH with mem_ready high: access abandoned.
    set_ir(2'd0, 6'b001000, 4'd3, 1'b1); bus.mem_ready = 1'b1; reset = 1'b1; #1;
    chk("midrst ir_w", int'(bus.ir_w), 0);
    chk("midrst pc_w", int'(bus.pc_w), 0);
    chk("midrst mem_req", int'(bus.mem_req), 0);
    nxt();
    reset = 1'b0; bus.mem_ready = 1'b0; #1;
    chk("midrst fetch", int'({bus.mem_req, bus.adr_src, bus.ir_w}), 4);

    // Table of instructions with fixed wait plans.
    for (int i = 0; i < 10; i++) run_instr(tbl[i], $sformatf("tbl%0d", i));

    // Random instructions against the reference model.
    for (int i = 0; i < 60; i++) begin
      rv.op    = 2'($urandom_range(3));
      rv.funct = 6'($urandom_range(63));
      if ($urandom_range(1) == 1) rv.funct[4:1] = 4'b0100 >> (2 * $urandom_range(1));
      rv.rd    = ($urandom_range(3) == 0) ? 4'd15 : 4'($urandom_range(14));
      rv.cond  = ($urandom_range(4) != 0);
      rv.wf    = $urandom_range(3);
      rv.wm    = $urandom_range(3);
      rv.e     = model(rv);
      run_instr(rv, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multicycle build of the CPU core. It replaces the single-cycle control path with a Moore state machine that steps the shared datapath through fetch, decode, execute, memory and writeback. The datapath holds one ALU, one memory port and one register file, so each instruction takes several cycles. The controller drives every mux select and write strobe, and it stalls on a ready/request handshake with unified memory.

## Interface
Parameters: none.

- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- op  input  2  instruction class from IR: 0 DP, 1 memory, 2 branch, 3 undefined
- funct  input  6  IR funct field: [5] immediate operand (DP), [4:1] cmd, [0] S bit (DP) / L bit (memory, 1 = load)
- rd  input  4  destination register from IR
- cond_ex  input  1  condition-check result, valid in DECODE
- mem_ready  input  1  memory completes current access this cycle
- mem_req  output  1  memory access request
- pc_w  output  1  PC write strobe
- ir_w  output  1  IR write strobe
- adr_src  output  1  memory address select: 0 PC, 1 ALUOut
- alu_src_a  output  1  ALU A select: 0 register A, 1 PC
- alu_src_b  output  2  ALU B select: 00 WriteData, 01 ExtImm, 10 constant 4
- result_src  output  2  result bus select: 00 ALUOut, 01 Data, 10 ALUResult
- reg_w  output  1  register-file write strobe
- mem_w  output  1  memory write enable, meaningful only with mem_req
- imm_src  output  2  extender mode: 00 DP imm8, 01 mem imm12, 10 branch imm24
- reg_src  output  2  [0] RA1 = R15, [1] RA2 = Rd
- alu_control  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- flag_w  output  2  [1] NZ write, [0] CV write

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - Waits until mem_ready. On the mem_ready cycle it asserts ir_w=1 and pc_w=1 (PC+4), then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=1, alu_src_b=10, ADD, result_src=10 (R15 reads PC+8); imm_src and reg_src are set from op.
  - If cond_ex=0 or op=3, go to FETCH with no writes.
  - Otherwise: op=0 goes to EXECI when funct[5]=1, else EXECR. op=1 goes to MEMADR. op=2 goes to BRANCH.
- MEMADR:
  - Outputs: alu_src_a=0, alu_src_b=01, ADD, imm_src=01.
  - funct[0]=1 goes to MEMRD, else MEMWR.
- MEMRD: mem_req=1, adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWR: mem_req=1, mem_w=1, adr_src=1. Holds until mem_ready, then goes to FETCH.
- MEMWB: result_src=01, reg_w=1, then FETCH. If rd=15, also pc_w=1 (reg_w still 1; the datapath routes R15).
- EXECR: alu_src_a=0, alu_src_b=00; alu_control and flag_w come from funct. Goes to ALUWB.
- EXECI: alu_src_a=0, alu_src_b=01, imm_src=00; alu_control and flag_w come from funct. Goes to ALUWB.
- ALUWB: result_src=00, reg_w=1, pc_w=(rd==15), then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=01, imm_src=10, ADD, result_src=10, pc_w=1, then FETCH.
- ALU decode (EXECR/EXECI only): cmd 4'b0100 gives 00, 0010 gives 01, 0000 gives 10, 1100 gives 11. Any other cmd gives 00.
- Flags (EXECR/EXECI only): flag_w[1]=funct[0]; flag_w[0]=funct[0] & (cmd is ADD or SUB). flag_w=00 in all other states.
- Any output not listed for a state is 0.

## Timing
- Reset:
  - While reset=1, state is forced to FETCH next edge.
  - All strobes and mem_req are forced to 0 (mem_req, pc_w, ir_w, reg_w, mem_w, flag_w); selects are 0.
  - First mem_req appears in the cycle after reset deasserts.
- Outputs are combinational of state, IR fields and mem_ready. There is no output register.
- Latency at zero wait states:
  - B: 3 cycles.
  - DP: 4 cycles.
  - STR: 4 cycles.
  - LDR: 5 cycles.
  - Each wait cycle on mem_ready adds 1 cycle.
- Handshake:
  - mem_req stays high, with address select stable, until mem_ready is sampled high.
  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset mid-access: mem_req drops in the reset cycle and the access is abandoned. No pc_w or ir_w is issued even if mem_ready=1 in that cycle.
- cond_ex is sampled only in DECODE.

## Structure
- ctrl_pkg holds:
  - the state enum;
  - op codes (OP_DP, OP_MEM, OP_BR);
  - ALU control codes;
  - the encodings for adr_src, alu_src_b, result_src and imm_src.
- Sub-module alu_dec: combinational funct-to-{alu_control, flag_w}, enabled by an alu_op input from the FSM.
- The state register and next-state/output logic live in multicycle_ctrl.

## Test plan
- Reset, then mem_ready tied 1, ADD op=0 funct=6'b001000 rd=3, cond_ex=1:
  - FETCH → DECODE → EXECR → ALUWB → FETCH.
  - reg_w=1 only in cycle 4; alu_control=00; flag_w=00.
- SUBS imm, funct=6'b100101, rd=2: EXECI asserts alu_control=01, flag_w=11, alu_src_b=01.
- LDR funct[0]=1, rd=15, mem_ready low for 2 cycles in MEMRD:
  - MEMRD holds 3 cycles with mem_req=1, adr_src=1.
  - MEMWB asserts reg_w=1, pc_w=1, result_src=01.
- STR funct[0]=0: MEMWR asserts mem_w=1 and mem_req=1; reg_w never asserts; returns to FETCH.
- Branch op=2 with cond_ex=0 → FETCH right after DECODE, no pc_w. With cond_ex=1 → BRANCH with pc_w=1, imm_src=10.
- Reset asserted in FETCH while mem_ready=1 → ir_w=0, pc_w=0, mem_req=0 that cycle; FETCH on the following cycle.
